// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Bridges a CPU load/store request onto a 2048x32 synchronous RAM. Two address windows
//   are mapped: a 4 KiB global area at 0x10010000 (words 0..1023) and a 4 KiB stack area
//   at 0x7FFFF000 (words 1024..2047). Sub-word stores become read-modify-write sequences.
//   Every accepted request gets exactly one single-cycle response pulse.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_signed           sign-extend loads
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           load result (0 on stores and errors), held until next response
//   resp_error           bad address, misalignment or illegal size
//   ram_addr/ram_we      RAM word index and write enable
//   ram_wdata/ram_rdata  RAM write word, RAM read word (one cycle after address)
module data_mem_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StData, StWrite, StResp} state_e;

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  // Request decode, evaluated on the raw request inputs at acceptance.
  logic        addr_ok;
  logic        misaligned;
  logic        req_err;
  logic        word_store;
  logic [10:0] req_idx;

  always_comb begin
    addr_ok    = (req_addr[31:12] == 20'h10010) || (req_addr[31:12] == 20'h7FFFF);
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err    = !addr_ok || (req_size == 2'b11) || misaligned;
    word_store = req_write && (req_size == 2'b10);
    // Bit 12 separates the windows: 0 in the global area, 1 in the stack area.
    req_idx    = req_addr[12:2];
  end

  // Lane handling on the word returned by the RAM.
  logic [4:0]  lane_sh;
  logic [31:0] lane_data;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    lane_sh   = {addr_lo_q, 3'b000};
    lane_data = ram_rdata >> lane_sh;
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_val = ram_rdata;
    endcase
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    merged    = (ram_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
      ram_addr   <= 11'h0;
      ram_we     <= 1'b0;
      ram_wdata  <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (word_store) begin
              state_q   <= StWrite;
              ram_addr  <= req_idx;
              ram_we    <= 1'b1;
              ram_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_q  <= StRead;
              ram_addr <= req_idx;
            end
          end
        end
        StRead: begin
          state_q <= StData;
        end
        StData: begin
          if (write_q) begin
            // ram_addr is still the target word, so the merge goes straight back.
            state_q   <= StWrite;
            ram_we    <= 1'b1;
            ram_wdata <= merged;
          end else begin
            state_q    <= StResp;
            ram_addr   <= 11'h0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        StWrite: begin
          state_q    <= StResp;
          ram_we     <= 1'b0;
          ram_addr   <= 11'h0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          ram_we     <= 1'b0;
          ram_addr   <= 11'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. A bench-side RAM serves the DUT; a separate
// reference memory plus a per-request prediction (latency, response, write word) forms the
// model, and a negedge process compares every cycle. Literal checks pin the model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Environment RAM.
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Model state.
  logic [31:0] ref_mem [0:2047];
  int          cyc = 0;
  int          acc_base = 0;
  int          exp_resp_at = 0;
  int          exp_we_at = -1;
  int          exp_rd_at = -1;
  int          exp_idx = 0;
  logic [31:0] exp_wword = '0;
  logic [31:0] p_rdata = '0;
  logic        p_err = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;
  logic        checking = 1'b0;

  // Observations for literal checks.
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;
  int          n_resp = 0;
  int          n_we = 0;

  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Outcome of one request from address-map and lane arithmetic.
  function automatic void predict(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output int lat, output logic [31:0] rd,
                                  output logic [31:0] wword, output int idx);
    logic        in_g, in_s;
    int          nb, off;
    logic [63:0] word, m, lane;
    in_g = (a >= 32'h1001_0000) && (a <= 32'h1001_0FFF);
    in_s = (a >= 32'h7FFF_F000) && (a <= 32'h7FFF_FFFF);
    idx  = in_g ? int'((a - 32'h1001_0000) / 4) :
           in_s ? 1024 + int'((a - 32'h7FFF_F000) / 4) : 0;
    nb   = (sz == 2'b11) ? 0 : (1 << sz);
    off  = int'(a % 4);
    err  = !(in_g || in_s) || (nb == 0) || ((off % ((nb == 0) ? 1 : nb)) != 0);
    word = {32'h0, ref_mem[idx]};
    rd    = '0;
    wword = '0;
    if (err) begin
      lat = 1;
    end else if (wr) begin
      if (nb == 4) begin
        lat   = 2;
        wword = wd;
      end else begin
        lat   = 4;
        m     = ((64'd1 << (8 * nb)) - 1) << (8 * off);
        wword = 32'((word & ~m) | (({32'h0, wd} << (8 * off)) & m));
      end
    end else begin
      lat  = 3;
      lane = word >> (8 * off);
      if (nb < 4) begin
        lane = lane % (64'd1 << (8 * nb));
        if (sg && (lane >= (64'd1 << (8 * nb - 1)))) lane = lane - (64'd1 << (8 * nb));
      end
      rd = 32'(lane);
    end
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      logic exp_ready;
      exp_ready = !((cyc > acc_base) && (cyc <= exp_resp_at));
      if (cyc == exp_resp_at) begin
        held_rdata = p_rdata;
        held_err   = p_err;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(cyc == exp_resp_at));
      chk("resp_rdata", resp_rdata, held_rdata);
      chk("resp_error", 32'(resp_error), 32'(held_err));
      chk("ram_we", 32'(ram_we), 32'(cyc == exp_we_at));
      if (cyc == exp_we_at) begin
        chk("ram_addr_wr", 32'(ram_addr), 32'(exp_idx));
        chk("ram_wdata", ram_wdata, exp_wword);
        ref_mem[exp_idx] = exp_wword;
      end
      if (cyc == exp_rd_at) chk("ram_addr_rd", 32'(ram_addr), 32'(exp_idx));
      if (exp_ready || (cyc == exp_resp_at)) chk("ram_addr_idle", 32'(ram_addr), 32'h0);
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_error;
        last_lat   = cyc - acc_base;
        n_resp++;
      end
      if (ram_we) n_we++;
    end
  end

  // Present one request for one cycle; returns one cycle after the acceptance edge.
  task automatic start_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    logic        err;
    int          lat, idx;
    logic [31:0] rd, ww;
    predict(wr, sz, sg, a, wd, err, lat, rd, ww, idx);
    acc_base    = cyc;
    exp_resp_at = cyc + lat;
    exp_idx     = idx;
    exp_wword   = ww;
    exp_rd_at   = (!err && (lat >= 3)) ? cyc + 1 : -1;
    exp_we_at   = (!err && wr) ? cyc + lat - 1 : -1;
    p_rdata     = rd;
    p_err       = err;
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_addr    = a;
    req_wdata   = wd;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= exp_resp_at) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    start_req(wr, sz, sg, a, wd);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0;
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram[0]        = 32'h0000_F080;
    ref_mem[0]    = 32'h0000_F080;
    ram[1024]     = 32'h1122_3344;
    ref_mem[1024] = 32'h1122_3344;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    @(posedge clk);
    checking = 1'b1;
    @(negedge clk); #1;
    chk("reset_ram_wdata", ram_wdata, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Word store then word load.
    run(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    chk("lit_wstore_lat", 32'(last_lat), 32'd2);
    chk("lit_ram1", ram[1], 32'hDEAD_BEEF);
    run(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
    chk("lit_wload_data", last_rdata, 32'hDEAD_BEEF);
    chk("lit_wload_err", 32'(last_err), 32'h0);
    chk("lit_wload_lat", 32'(last_lat), 32'd3);

    // Byte store into the stack window.
    w0 = n_we;
    run(1'b1, 2'b00, 1'b0, 32'h7FFF_F002, 32'h0000_00AA);
    chk("lit_ram1024", ram[1024], 32'h11AA_3344);
    chk("lit_bstore_we_once", 32'(n_we - w0), 32'd1);
    chk("lit_bstore_lat", 32'(last_lat), 32'd4);

    // Sign/zero extension.
    run(1'b0, 2'b00, 1'b1, 32'h1001_0000, 32'h0);
    chk("lit_sbyte", last_rdata, 32'hFFFF_FF80);
    run(1'b0, 2'b01, 1'b0, 32'h1001_0000, 32'h0);
    chk("lit_uhalf", last_rdata, 32'h0000_F080);

    // Error responses.
    w0 = n_we;
    run(1'b0, 2'b10, 1'b0, 32'h1001_1000, 32'h0);
    chk("lit_badaddr_err", 32'(last_err), 32'h1);
    chk("lit_badaddr_data", last_rdata, 32'h0);
    chk("lit_badaddr_lat", 32'(last_lat), 32'd1);
    run(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h0000_1234);
    chk("lit_misal_err", 32'(last_err), 32'h1);
    chk("lit_misal_lat", 32'(last_lat), 32'd1);
    chk("lit_err_no_we", 32'(n_we - w0), 32'd0);

    // Reset while a sub-word store sits in DATA.
    r0 = n_resp;
    w0 = n_we;
    start_req(1'b1, 2'b00, 1'b0, 32'h7FFF_F001, 32'h0000_0055);
    @(negedge clk); #1;
    rst_n       = 1'b0;
    exp_resp_at = cyc;
    exp_we_at   = -1;
    exp_rd_at   = -1;
    held_rdata  = '0;
    held_err    = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("lit_rst_ready", 32'(req_ready), 32'h1);
    repeat (4) begin
      @(negedge clk); #1;
    end
    chk("lit_rst_ram", ram[1024], 32'h11AA_3344);
    chk("lit_rst_no_resp", 32'(n_resp - r0), 32'd0);
    chk("lit_rst_no_we", 32'(n_we - w0), 32'd0);

    // Further lanes, boundaries and illegal encodings.
    run(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_8001);
    chk("lit_ram0_half", ram[0], 32'h8001_F080);
    run(1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0);
    chk("lit_shalf_hi", last_rdata, 32'hFFFF_8001);
    run(1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0);
    chk("lit_ubyte3", last_rdata, 32'h0000_0080);
    run(1'b1, 2'b10, 1'b0, 32'h7FFF_FFFC, 32'h1234_5678);
    chk("lit_ram2047", ram[2047], 32'h1234_5678);
    run(1'b0, 2'b00, 1'b1, 32'h7FFF_FFFF, 32'h0);
    chk("lit_stack_top_byte", last_rdata, 32'h0000_0012);
    run(1'b0, 2'b00, 1'b0, 32'h1001_0FFF, 32'h0);
    run(1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0);
    chk("lit_size11_err", 32'(last_err), 32'h1);
    run(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0);
    run(1'b0, 2'b00, 1'b0, 32'h1000_FFFF, 32'h0);
    run(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 2'b10, 1'b0, 32'h7FFF_F000, 32'h0);
    chk("lit_stack_base", last_rdata, 32'h11AA_3344);

    repeat (2) begin
      @(negedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
